// File: rtl/hazard_stall_unit_if.sv
// ---------------------------------------------------------------------------
// hazard_stall_unit_if
//   Bundles the pipeline-side and data-memory-side signals of the interlock
//   controller so the datapath and the controller connect through one port.
//
//   Pipeline / memory side (master drives, slave receives):
//     id_ir[15:0]   instruction currently in ID
//     id_valid      id_ir is a real instruction (0 = bubble)
//     flush         taken control transfer, kill the instruction leaving ID
//     dmem_resp     data memory completed the current access this cycle
//   Controller side (slave drives, master receives):
//     pipe_en       load enable for all pipeline latches and PC
//     ifid_hold     hold PC and IF/ID while ID/EX advances
//     idex_bubble   load a NOP into ID/EX instead of the ID instruction
//     dmem_read     data-memory read request
//     dmem_write    data-memory write request
//     mem_phase     0 = address access, 1 = indirect access of LDI/STI
//     stall_count   saturating count of cycles lost to stalls and bubbles
// ---------------------------------------------------------------------------
interface hazard_stall_unit_if #(
   parameter int CNT_W = 16
);
   logic [15:0]      id_ir;
   logic             id_valid;
   logic             flush;
   logic             dmem_resp;
   logic             pipe_en;
   logic             ifid_hold;
   logic             idex_bubble;
   logic             dmem_read;
   logic             dmem_write;
   logic             mem_phase;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output id_ir, id_valid, flush, dmem_resp,
      input  pipe_en, ifid_hold, idex_bubble, dmem_read, dmem_write,
             mem_phase, stall_count
   );

   modport slave (
      input  id_ir, id_valid, flush, dmem_resp,
      output pipe_en, ifid_hold, idex_bubble, dmem_read, dmem_write,
             mem_phase, stall_count
   );
endinterface

// File: rtl/hazard_stall_unit.sv
// ---------------------------------------------------------------------------
// hazard_stall_unit
//   Interlock controller for the five-stage LC-3b pipeline. It shadows the
//   ID/EX and EX/MEM contents, inserts one bubble for load-use hazards that
//   forwarding cannot cover, and sequences the one- or two-access data-memory
//   handshake in MEM (LDI/STI take an indirect second access). While a memory
//   op in MEM is unfinished the whole pipeline is frozen via pipe_en.
//
//   Ports:
//     clk        clock
//     reset_n    synchronous, active-low reset
//     bus        hazard_stall_unit_if.slave (see interface for signal list)
// ---------------------------------------------------------------------------
module hazard_stall_unit #(
   parameter int CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   hazard_stall_unit_if.slave    bus
);

   // LC-3b opcodes
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_NOT = 4'b1001;
   localparam logic [3:0] OP_SHF = 4'b1101;
   localparam logic [3:0] OP_JMP = 4'b1100;
   localparam logic [3:0] OP_JSR = 4'b0100;
   localparam logic [3:0] OP_LDB = 4'b0010;
   localparam logic [3:0] OP_LDI = 4'b1010;
   localparam logic [3:0] OP_LDR = 4'b0110;
   localparam logic [3:0] OP_STB = 4'b0011;
   localparam logic [3:0] OP_STI = 4'b1011;
   localparam logic [3:0] OP_STR = 4'b0111;

   // MEM access phases
   localparam logic [0:0] PH0 = 1'b0;
   localparam logic [0:0] PH1 = 1'b1;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_ONE;
   endfunction

   // ex_slot and mem_slot shadows; the opcode rides along in ex so that
   // MEM can decode the access type once the op arrives there
   logic             ex_vld_q;
   logic [2:0]       ex_dest_q;
   logic             ex_load_q;
   logic [3:0]       ex_opc_q;
   logic             mem_vld_q;
   logic [3:0]       mem_opc_q;
   logic [0:0]       phase_q, phase_d;
   logic [CNT_W-1:0] cnt_q;

   logic [3:0] opc;
   logic [2:0] sr1, sr2, st_src;
   logic       need_sr1, need_sr2, need_st, id_is_load;
   logic       hazard;
   logic       mem_is_mem, mem_indirect, mem_done;
   logic       rd, wr, pipe_en;
   logic       stall_inc;

   // ir[4:3] never selects a source register
   logic       unused_ir_bits;
   assign unused_ir_bits = ^bus.id_ir[4:3];

   // ---- ID decode and load-use detection ----
   always_comb begin
      opc        = bus.id_ir[15:12];
      st_src     = bus.id_ir[11:9];
      sr1        = bus.id_ir[8:6];
      sr2        = bus.id_ir[2:0];
      need_sr1   = 1'b0;
      case (opc)
         OP_ADD, OP_AND, OP_NOT, OP_SHF, OP_JMP,
         OP_LDB, OP_LDI, OP_LDR, OP_STB, OP_STI, OP_STR: need_sr1 = 1'b1;
         OP_JSR:  need_sr1 = ~bus.id_ir[11];   // only JSRR reads a register
         default: need_sr1 = 1'b0;
      endcase
      need_sr2   = ((opc == OP_ADD) || (opc == OP_AND)) && !bus.id_ir[5];
      need_st    = (opc == OP_STB) || (opc == OP_STI) || (opc == OP_STR);
      id_is_load = (opc == OP_LDB) || (opc == OP_LDR) || (opc == OP_LDI);
      hazard     = bus.id_valid && ex_vld_q && ex_load_q &&
                   ((need_sr1 && (sr1 == ex_dest_q)) ||
                    (need_sr2 && (sr2 == ex_dest_q)) ||
                    (need_st  && (st_src == ex_dest_q)));
   end

   // ---- MEM access sequencing ----
   always_comb begin
      mem_is_mem   = mem_vld_q &&
                     ((mem_opc_q == OP_LDB) || (mem_opc_q == OP_LDR) ||
                      (mem_opc_q == OP_LDI) || (mem_opc_q == OP_STB) ||
                      (mem_opc_q == OP_STR) || (mem_opc_q == OP_STI));
      mem_indirect = (mem_opc_q == OP_LDI) || (mem_opc_q == OP_STI);
      phase_d      = phase_q;
      rd           = 1'b0;
      wr           = 1'b0;
      mem_done     = 1'b0;
      if (!mem_is_mem) begin
         phase_d = PH0;
      end else if (phase_q == PH0) begin
         // STI's first access reads the pointer, so it is a read
         rd = (mem_opc_q != OP_STB) && (mem_opc_q != OP_STR);
         wr = (mem_opc_q == OP_STB) || (mem_opc_q == OP_STR);
         if (bus.dmem_resp) begin
            if (mem_indirect) phase_d  = PH1;
            else              mem_done = 1'b1;
         end
      end else begin
         rd = (mem_opc_q == OP_LDI);
         wr = (mem_opc_q == OP_STI);
         if (bus.dmem_resp) begin
            mem_done = 1'b1;
            phase_d  = PH0;
         end
      end
      pipe_en   = !mem_is_mem || mem_done;
      // a flush-driven bubble is not a lost cycle; the branch already paid
      stall_inc = !pipe_en || (hazard && !bus.flush);
   end

   // ---- control state ----
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ex_vld_q  <= 1'b0;
         mem_vld_q <= 1'b0;
         phase_q   <= PH0;
         cnt_q     <= '0;
      end else begin
         phase_q <= phase_d;
         if (stall_inc) cnt_q <= sat_inc(cnt_q);
         if (pipe_en) begin
            mem_vld_q <= ex_vld_q;
            ex_vld_q  <= (bus.flush || hazard) ? 1'b0 : bus.id_valid;
         end
      end
   end

   // ---- shadow payload, qualified by the valid bits above ----
   always_ff @(posedge clk) begin
      if (pipe_en) begin
         mem_opc_q <= ex_opc_q;
         ex_dest_q <= bus.id_ir[11:9];
         ex_load_q <= id_is_load;
         ex_opc_q  <= opc;
      end
   end

   assign bus.pipe_en     = pipe_en;
   assign bus.idex_bubble = bus.flush || hazard;
   assign bus.ifid_hold   = !bus.flush && hazard;
   assign bus.dmem_read   = rd;
   assign bus.dmem_write  = wr;
   assign bus.mem_phase   = phase_q[0];
   assign bus.stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_unit
//   Cycle-by-cycle scoreboard bench. Each stimulus step pushes the outputs
//   expected in that cycle; a negedge monitor pops and compares them.
// ---------------------------------------------------------------------------
module tb_hazard_stall_unit;

   localparam int CNT_W = 16;

   localparam logic [15:0] I_LDR  = 16'h6280;  // LDR R1,R2,#0
   localparam logic [15:0] I_ADDH = 16'h1644;  // ADD R3,R1,R4
   localparam logic [15:0] I_ADDI = 16'h1261;  // ADD R1,R1,#1
   localparam logic [15:0] I_ADDR = 16'h1441;  // ADD R2,R1,R1
   localparam logic [15:0] I_LDI  = 16'hAA80;  // LDI R5,R2,#0
   localparam logic [15:0] I_STI  = 16'hB080;  // STI R0,R2,#0
   localparam logic [15:0] I_LDB  = 16'h2280;  // LDB R1,R2,#0
   localparam logic [15:0] I_STR  = 16'h7382;  // STR R1,R6,#2

   typedef struct {
      int          id;
      logic        pe, hold, bub, rd, wr, ph;
      logic [15:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;
   int   tests = 0;
   int   fails = 0;
   int   step_no = 0;
   exp_t sb_q[$];

   hazard_stall_unit_if #(.CNT_W(CNT_W)) bus();

   hazard_stall_unit #(.CNT_W(CNT_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp_v);
      tests++;
      if (obs !== exp_v) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic step(input logic rstn, input logic [15:0] ir,
                       input logic vld, input logic fl, input logic rsp,
                       input logic epe, input logic ehold, input logic ebub,
                       input logic erd, input logic ewr, input logic eph,
                       input int ecnt);
      exp_t e;
      @(posedge clk);
      #1;
      reset_n       = rstn;
      bus.id_ir     = ir;
      bus.id_valid  = vld;
      bus.flush     = fl;
      bus.dmem_resp = rsp;
      e.id   = step_no;
      e.pe   = epe;
      e.hold = ehold;
      e.bub  = ebub;
      e.rd   = erd;
      e.wr   = ewr;
      e.ph   = eph;
      e.cnt  = ecnt[15:0];
      sb_q.push_back(e);
      step_no++;
   endtask

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         check_val($sformatf("s%0d.pipe_en", e.id),     {31'b0, bus.pipe_en},     {31'b0, e.pe});
         check_val($sformatf("s%0d.ifid_hold", e.id),   {31'b0, bus.ifid_hold},   {31'b0, e.hold});
         check_val($sformatf("s%0d.idex_bubble", e.id), {31'b0, bus.idex_bubble}, {31'b0, e.bub});
         check_val($sformatf("s%0d.dmem_read", e.id),   {31'b0, bus.dmem_read},   {31'b0, e.rd});
         check_val($sformatf("s%0d.dmem_write", e.id),  {31'b0, bus.dmem_write},  {31'b0, e.wr});
         check_val($sformatf("s%0d.mem_phase", e.id),   {31'b0, bus.mem_phase},   {31'b0, e.ph});
         check_val($sformatf("s%0d.stall_count", e.id), {16'b0, bus.stall_count}, {16'b0, e.cnt});
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n       = 1'b0;
      bus.id_ir     = '0;
      bus.id_valid  = 1'b0;
      bus.flush     = 1'b0;
      bus.dmem_resp = 1'b0;
      repeat (2) @(posedge clk);

      //    rst ir      vld fl rsp  pe ho bu rd wr ph cnt
      // load-use: LDR R1 then ADD R3,R1,R4, immediate resp
      step(1, I_LDR,  1, 0, 0,   1, 0, 0, 0, 0, 0, 0);
      step(1, I_ADDH, 1, 0, 0,   1, 1, 1, 0, 0, 0, 0);
      step(1, I_ADDH, 1, 0, 1,   1, 0, 0, 1, 0, 0, 1);
      step(1, 16'h0,  0, 0, 0,   1, 0, 0, 0, 0, 0, 1);
      step(1, 16'h0,  0, 0, 0,   1, 0, 0, 0, 0, 0, 1);
      step(0, 16'h0,  0, 0, 0,   1, 0, 0, 0, 0, 0, 1);
      // non-load producer never stalls
      step(1, I_ADDI, 1, 0, 0,   1, 0, 0, 0, 0, 0, 0);
      step(1, I_ADDR, 1, 0, 0,   1, 0, 0, 0, 0, 0, 0);
      step(1, 16'h0,  0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
      step(1, 16'h0,  0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
      // LDI with two-cycle resp delay per access
      step(1, I_LDI,  1, 0, 0,   1, 0, 0, 0, 0, 0, 0);
      step(1, 16'h0,  0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
      step(1, 16'h0,  0, 0, 0,   0, 0, 0, 1, 0, 0, 0);
      step(1, 16'h0,  0, 0, 0,   0, 0, 0, 1, 0, 0, 1);
      step(1, 16'h0,  0, 0, 1,   0, 0, 0, 1, 0, 0, 2);
      step(1, 16'h0,  0, 0, 0,   0, 0, 0, 1, 0, 1, 3);
      step(1, 16'h0,  0, 0, 0,   0, 0, 0, 1, 0, 1, 4);
      step(1, 16'h0,  0, 0, 1,   1, 0, 0, 1, 0, 1, 5);
      step(1, 16'h0,  0, 0, 0,   1, 0, 0, 0, 0, 0, 5);
      step(0, 16'h0,  0, 0, 0,   1, 0, 0, 0, 0, 0, 5);
      // STI with immediate resps
      step(1, I_STI,  1, 0, 0,   1, 0, 0, 0, 0, 0, 0);
      step(1, 16'h0,  0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
      step(1, 16'h0,  0, 0, 1,   0, 0, 0, 1, 0, 0, 0);
      step(1, 16'h0,  0, 0, 1,   1, 0, 0, 0, 1, 1, 1);
      step(1, 16'h0,  0, 0, 0,   1, 0, 0, 0, 0, 0, 1);
      // LDB R1 in EX, STR R1 in ID with flush
      step(1, I_LDB,  1, 0, 0,   1, 0, 0, 0, 0, 0, 1);
      step(1, I_STR,  1, 1, 0,   1, 0, 1, 0, 0, 0, 1);
      step(1, 16'h0,  0, 0, 1,   1, 0, 0, 1, 0, 0, 1);
      step(1, 16'h0,  0, 0, 0,   1, 0, 0, 0, 0, 0, 1);
      // same pair without flush: store-source hazard, then delayed load resp
      step(1, I_LDB,  1, 0, 0,   1, 0, 0, 0, 0, 0, 1);
      step(1, I_STR,  1, 0, 0,   1, 1, 1, 0, 0, 0, 1);
      step(1, I_STR,  1, 0, 0,   0, 0, 0, 1, 0, 0, 2);
      step(1, I_STR,  1, 0, 1,   1, 0, 0, 1, 0, 0, 3);
      step(1, 16'h0,  0, 0, 0,   1, 0, 0, 0, 0, 0, 3);
      step(1, 16'h0,  0, 0, 1,   1, 0, 0, 0, 1, 0, 3);
      step(1, 16'h0,  0, 0, 0,   1, 0, 0, 0, 0, 0, 3);
      // reset asserted while LDI sits in PH1
      step(1, I_LDI,  1, 0, 0,   1, 0, 0, 0, 0, 0, 3);
      step(1, 16'h0,  0, 0, 0,   1, 0, 0, 0, 0, 0, 3);
      step(1, 16'h0,  0, 0, 1,   0, 0, 0, 1, 0, 0, 3);
      step(0, 16'h0,  0, 0, 0,   0, 0, 0, 1, 0, 1, 4);
      step(1, 16'h0,  0, 0, 0,   1, 0, 0, 0, 0, 0, 0);

      repeat (2) @(negedge clk);
      #1;
      if (sb_q.size() != 0) check_val("sb_drain", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Pipeline interlock controller for the five-stage LC-3b datapath: it covers every data-hazard case that operand forwarding cannot resolve, plus data-memory wait states. It keeps a shadow copy of the ID/EX and EX/MEM stage contents and detects load-use hazards for the instruction in ID. It sequences the one- and two-access data-memory handshake in MEM, including LDI/STI indirection. It drives the global pipeline enable, the IF/ID hold and the ID/EX bubble.

## Interface
- Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter.
- Ports:
- clk  input  1  clock.
- reset_n  input  1  reset; synchronous, active-low.
- id_ir  input  16  instruction in ID.
- id_valid  input  1  id_ir is a real instruction (0 = bubble).
- flush  input  1  taken control transfer; kill the instruction leaving ID.
- dmem_resp  input  1  data memory completed the current access this cycle.
- pipe_en  output  1  load enable for all pipeline latches and PC.
- ifid_hold  output  1  hold PC and IF/ID while ID/EX advances.
- idex_bubble  output  1  load a NOP into ID/EX instead of the ID instruction.
- dmem_read  output  1  data-memory read request.
- dmem_write  output  1  data-memory write request.
- mem_phase  output  1  0 = first (address) access; 1 = indirect second access of LDI/STI.
- stall_count  output  CNT_W  cycles lost to stalls and bubbles, saturating.

## Operation
- Decode of id_ir:
- sr1 = ir[8:6] is needed by ADD, AND, NOT, SHF, JMP, JSRR (JSR with ir[11]=0), LDB, LDI, LDR, STB, STI and STR.
- sr2 = ir[2:0] is needed by ADD and AND when ir[5]=0.
- Store source ir[11:9] is needed by STB, STI and STR.
- A load is LDB, LDR or LDI; dest = ir[11:9].
- A memory op is any load or any store. TRAP vector fetch is handled outside this block.
- Shadow slots:
  - ex_slot = {valid, dest, is_load}.
  - mem_slot = {valid, opcode}.
- Load-use hazard: id_valid, ex_slot.valid and ex_slot.is_load are all set, and any needed source of id_ir equals ex_slot.dest.
- When pipe_en=1:
  - mem_slot <= ex_slot.
  - If flush or hazard, ex_slot <= invalid. Otherwise ex_slot <= decode(id_ir), with valid = id_valid.
- When pipe_en=0, all slots hold and flush is ignored. The branch unit holds flush high until pipe_en=1.
- Output priority:
  - flush=1: idex_bubble=1, ifid_hold=0.
  - flush=0 with a hazard: idex_bubble=1, ifid_hold=1.
  - Otherwise both are 0.
- MEM FSM (mem_phase register), active when mem_slot holds a valid memory op:
- PH0 (mem_phase=0):
  - Read ops and STI: dmem_read=1. STB and STR: dmem_write=1.
  - On dmem_resp: LDI/STI go to PH1, all other ops complete.
- PH1 (mem_phase=1):
  - LDI: dmem_read=1. STI: dmem_write=1.
  - On dmem_resp the op completes and the FSM returns to PH0.
- pipe_en is 0 while mem_slot holds a valid memory op that has not completed. pipe_en=1 in the completion cycle and whenever MEM holds no memory op.
- stall_count increments by 1 in each cycle where pipe_en=0, or where pipe_en=1 and idex_bubble=1 due to a hazard; it holds at all-ones.
- Reset values:
  - All slots invalid, mem_phase=0, stall_count=0.
  - Outputs: pipe_en=1; ifid_hold, idex_bubble, dmem_read and dmem_write all 0.

## Timing
- All outputs are combinational from registered state, id_ir, id_valid, flush and dmem_resp. dmem_resp reaches pipe_en in the same cycle.
- Load-use costs exactly one bubble cycle. On the next cycle the load is in MEM and its result is forwarded from EX/MEM or MEM/WB.
- A single access with resp in the request cycle costs 0 stall cycles. Each cycle of resp delay adds 1.
- LDI/STI cost at least 1 stall cycle (PH0 completion → PH1). dmem_read/write stay high across the phase boundary, with mem_phase switching on the clock edge.
- A hazard while pipe_en=0 has no effect until pipe_en rises. idex_bubble and ifid_hold may assert, but the latches are disabled.
- Reset asserted mid-access (PH1): the FSM returns to PH0 and the slots invalidate on that edge; no request is driven in the following cycle.
- A dest in ex_slot that matches no needed source, and a non-load in ex_slot, never stall.

## Test plan
- LDR R1,R2,#0 then ADD R3,R1,R4 with resp in the request cycle → one cycle with idex_bubble=1 and ifid_hold=1; stall_count=1.
- ADD R1,R1,#1 then ADD R2,R1,R1 → no hold and no bubble; stall_count stays 0.
- LDI R5 with dmem_resp delayed 2 cycles per access:
  - dmem_read=1 for 6 cycles; mem_phase goes 0,0,0,1,1,1.
  - pipe_en=0 for 5 cycles; stall_count=5.
- STI R0 with immediate resps → PH0 dmem_read=1, then PH1 dmem_write=1 with mem_phase=1; exactly 1 stall cycle.
- LDB R1 in EX with STR R1,R6,#2 in ID and flush=1 → idex_bubble=1, ifid_hold=0; stall_count unchanged.
- reset_n=0 during LDI PH1 → next cycle pipe_en=1, dmem_read=0, mem_phase=0, stall_count=0.
